// File: rtl/gat_bram_loader_if.sv
// Valid/ready word stream feeding the BRAM loader.
//   s_data  : 32-bit payload, driven by the stream source
//   s_valid : payload valid, driven by the stream source
//   s_ready : engine accepts a word, driven by the loader
// The master modport is the stream source (DMA side). The slave modport is the loader.
interface gat_bram_loader_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/gat_bram_loader.sv
// Host-side BRAM write engine.
// It converts a valid/ready word stream into sequential BRAM port-A write strobes.
// It raises load_done once the last word has been committed.
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   start/abort     : one-cycle control pulses
//   num_words       : load length, sampled on an accepted start
//   s               : word stream (slave side)
//   bram_*          : port-A write bus; bram_addra is a byte address (word index << 2)
//   load_done       : level, every word of the load is committed
//   busy            : engine is accepting words
//   len_err         : sticky, a start was rejected for an oversize length
//   word_cnt        : words accepted in the current load
module gat_bram_loader #(
    parameter int unsigned DEPTH  = 242101,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W:0]      num_words,
    gat_bram_loader_if.slave     s,
    output logic [31:0]          bram_din,
    output logic                 bram_ena,
    output logic                 bram_wea,
    output logic [ADDR_W+1:0]    bram_addra,
    output logic                 load_done,
    output logic                 busy,
    output logic                 len_err,
    output logic [ADDR_W:0]      word_cnt
);
    localparam int unsigned CW = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_W = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t             state_q, state_n;
    logic [ADDR_W:0]    len_q, len_n;
    logic [ADDR_W:0]    cnt_q, cnt_n;
    logic [ADDR_W:0]    cnt_inc;
    logic [31:0]        din_q, din_n;
    logic [ADDR_W+1:0]  addr_q, addr_n;
    logic               ena_q, ena_n;
    logic               err_q, err_n;
    logic               ready_q, ready_n;
    logic               done_q, done_n;
    logic               hs;

    assign hs      = ready_q & s.s_valid;
    assign cnt_inc = cnt_q + CW'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_q;
        len_n   = len_q;
        cnt_n   = cnt_q;
        din_n   = din_q;
        addr_n  = addr_q;
        ena_n   = 1'b0;
        err_n   = err_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (num_words > DEPTH_W) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b0;
                        len_n   = num_words;
                        cnt_n   = '0;
                        state_n = (num_words == '0) ? DONE : LOAD;
                    end
                end
            end
            LOAD: begin
                // A handshake in an abort cycle has already been seen by the
                // source, so its write is still issued.
                if (hs) begin
                    ena_n  = 1'b1;
                    din_n  = s.s_data;
                    addr_n = {cnt_q[ADDR_W-1:0], 2'b00};
                    cnt_n  = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_n = DRAIN;
                    end
                end
                if (abort) begin
                    state_n = IDLE;
                end
            end
            DRAIN: begin
                state_n = abort ? IDLE : DONE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Status flags are registered copies of the state being entered.
        ready_n = (state_n == LOAD);
        done_n  = (state_n == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            din_q   <= '0;
            addr_q  <= '0;
            ena_q   <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            len_q   <= len_n;
            cnt_q   <= cnt_n;
            din_q   <= din_n;
            addr_q  <= addr_n;
            ena_q   <= ena_n;
            err_q   <= err_n;
            ready_q <= ready_n;
            done_q  <= done_n;
        end
    end

    assign s.s_ready  = ready_q;
    assign busy       = ready_q;
    assign bram_din   = din_q;
    assign bram_ena   = ena_q;
    assign bram_wea   = ena_q;
    assign bram_addra = addr_q;
    assign load_done  = done_q;
    assign len_err    = err_q;
    assign word_cnt   = cnt_q;
endmodule

// File: tb/tb_gat_bram_loader.sv
// Testbench for gat_bram_loader.
// Part 1 applies a table of directed vectors that carry hand-computed expected values.
// The remaining parts check the DUT cycle by cycle against a transaction-level model.
// That model also rebuilds the BRAM contents from the observed strobes.
module tb_gat_bram_loader;
    localparam int unsigned DEPTH  = 242101;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CW     = ADDR_W + 1;
    localparam int unsigned AW     = ADDR_W + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] num_words;
    logic [31:0]   bram_din;
    logic          bram_ena;
    logic          bram_wea;
    logic [AW-1:0] bram_addra;
    logic          load_done;
    logic          busy;
    logic          len_err;
    logic [CW-1:0] word_cnt;

    gat_bram_loader_if s_if ();

    gat_bram_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .num_words  (num_words),
        .s          (s_if),
        .bram_din   (bram_din),
        .bram_ena   (bram_ena),
        .bram_wea   (bram_wea),
        .bram_addra (bram_addra),
        .load_done  (load_done),
        .busy       (busy),
        .len_err    (len_err),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // An all-X expectation in the table means "not checked".
    task automatic chk_opt(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (!$isunknown(exp)) chk(name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // The model tracks the load as a transaction: the words the engine has taken, how many are expected, and whether the load is complete.
    bit           m_loading, m_tail, m_done, m_err, m_ena, m_check;
    int unsigned  m_len, m_cnt, m_addr;
    logic [31:0]  m_din;
    logic [31:0]  sent[$];
    logic [31:0]  mem[int];

    function automatic void model_reset();
        m_loading = 0; m_tail = 0; m_done = 0; m_err = 0; m_ena = 0; m_check = 0;
        m_len = 0; m_cnt = 0; m_addr = 0; m_din = '0;
        sent.delete();
        mem.delete();
    endfunction

    function automatic void model_step(input bit st, input bit ab, input int unsigned nw,
                                       input bit v, input logic [31:0] d);
        bit take;
        take    = m_loading && v;
        m_ena   = take;
        m_check = 0;
        if (take) begin
            m_din  = d;
            m_addr = m_cnt * 4;
            m_cnt++;
            sent.push_back(d);
        end
        if (m_loading) begin
            if (ab) m_loading = 0;
            else if (m_cnt == m_len) begin
                m_loading = 0;
                m_tail    = 1;
            end
        end else if (m_tail) begin
            m_tail = 0;
            if (!ab) begin
                m_done  = 1;
                m_check = 1;
            end
        end else if (st) begin
            if (nw > DEPTH) begin
                m_err  = 1;
                m_done = 0;
            end else begin
                m_err     = 0;
                m_len     = nw;
                m_cnt     = 0;
                m_done    = (nw == 0);
                m_loading = (nw != 0);
                sent.delete();
                mem.delete();
            end
        end
    endfunction

    // Applies one cycle of inputs, advances the model, and checks every output.
    task automatic cycle(input bit r, input bit st, input bit ab, input int unsigned nw,
                         input bit v, input logic [31:0] d);
        int idx;
        rst = r; start = st; abort = ab; num_words = CW'(nw);
        s_if.s_valid = v; s_if.s_data = d;
        if (r) model_reset();
        else   model_step(st, ab, nw, v, d);
        @(posedge clk); #1;
        chk("s_ready",    32'(s_if.s_ready), 32'(m_loading));
        chk("busy",       32'(busy),         32'(m_loading));
        chk("bram_ena",   32'(bram_ena),     32'(m_ena));
        chk("bram_wea",   32'(bram_wea),     32'(m_ena));
        chk("bram_addra", 32'(bram_addra),   32'(m_addr));
        chk("bram_din",   bram_din,          m_din);
        chk("load_done",  32'(load_done),    32'(m_done));
        chk("len_err",    32'(len_err),      32'(m_err));
        chk("word_cnt",   32'(word_cnt),     32'(m_cnt));
        if (bram_ena === 1'b1) begin
            idx = 32'(bram_addra[AW-1:2]);
            mem[idx] = bram_din;
        end
        if (m_check) begin
            for (int i = 0; i < sent.size(); i++) begin
                if (mem.exists(i)) chk("bram_word", mem[i], sent[i]);
                else               chk("bram_word", 32'hxxxx_xxxx, sent[i]);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 32'h0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          st;
        int unsigned nw;
        bit          v;
        logic [31:0] d;
        logic        r;
        logic        ena;
        logic [31:0] addr;
        logic [31:0] din;
        logic        done;
        logic        err;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        bit          st, ab, v;
        int unsigned nw;

        tbl[0]  = '{1, 4,       0, 32'h0,  1, 0, 0,  32'h0,  0, 0, 0};
        tbl[1]  = '{0, 0,       1, 32'hA0, 1, 1, 0,  32'hA0, 0, 0, 1};
        tbl[2]  = '{0, 0,       1, 32'hA1, 1, 1, 4,  32'hA1, 0, 0, 2};
        tbl[3]  = '{0, 0,       1, 32'hA2, 1, 1, 8,  32'hA2, 0, 0, 3};
        tbl[4]  = '{0, 0,       1, 32'hA3, 0, 1, 12, 32'hA3, 0, 0, 4};
        tbl[5]  = '{0, 0,       1, 32'hFF, 0, 0, 12, 32'hA3, 1, 0, 4};
        tbl[6]  = '{0, 0,       0, 32'h0,  0, 0, 12, 32'hA3, 1, 0, 4};
        tbl[7]  = '{1, DEPTH+1, 0, 32'h0,  0, 0, 12, 32'hA3, 0, 1, 4};
        tbl[8]  = '{1, DEPTH+1, 0, 32'h0,  0, 0, 12, 32'hA3, 0, 1, 4};
        tbl[9]  = '{1, 0,       0, 32'h0,  0, 0, 12, 32'hA3, 1, 0, 'x};
        tbl[10] = '{0, 0,       1, 32'h77, 0, 0, 12, 32'hA3, 1, 0, 'x};
        tbl[11] = '{1, 1,       0, 32'h0,  1, 0, 12, 32'hA3, 0, 0, 0};
        tbl[12] = '{0, 0,       1, 32'h55, 0, 1, 0,  32'h55, 0, 0, 1};
        tbl[13] = '{0, 0,       0, 32'h0,  0, 0, 0,  32'h55, 1, 0, 1};

        rst = 1; start = 0; abort = 0; num_words = '0;
        s_if.s_valid = 1; s_if.s_data = 32'hDEAD_BEEF;

        // Reset with a valid stream present, then 10 idle cycles without a strobe.
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 32'h1000 + 32'(i));

        // Directed vectors: 4-word load, oversize/zero lengths, restart from DONE.
        for (int i = 0; i < 14; i++) begin
            rst = 0; abort = 0;
            start = tbl[i].st; num_words = CW'(tbl[i].nw);
            s_if.s_valid = tbl[i].v; s_if.s_data = tbl[i].d;
            @(posedge clk); #1;
            chk_opt("tbl_s_ready",   32'(s_if.s_ready), 32'(tbl[i].r));
            chk_opt("tbl_busy",      32'(busy),         32'(tbl[i].r));
            chk_opt("tbl_bram_ena",  32'(bram_ena),     32'(tbl[i].ena));
            chk_opt("tbl_bram_wea",  32'(bram_wea),     32'(tbl[i].ena));
            chk_opt("tbl_addra",     32'(bram_addra),   tbl[i].addr);
            chk_opt("tbl_din",       bram_din,          tbl[i].din);
            chk_opt("tbl_load_done", 32'(load_done),    32'(tbl[i].done));
            chk_opt("tbl_len_err",   32'(len_err),      32'(tbl[i].err));
            chk_opt("tbl_word_cnt",  32'(word_cnt),     tbl[i].cnt);
        end

        cycle(1, 0, 0, 0, 0, 32'h0);

        // Five words with valid toggling 1,0,0: strobes only on handshakes.
        cycle(0, 1, 0, 5, 0, 32'h0);
        for (int i = 0; i < 15; i++) cycle(0, 0, 0, 0, (i % 3) == 0, 32'hB0 + 32'(i));
        idle(2);

        // Rejected start sets len_err. An abort after 3 of 8 words returns to IDLE without load_done.
        cycle(0, 1, 0, DEPTH + 1, 0, 32'h0);
        cycle(0, 1, 0, 8, 0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 32'hC0 + 32'(i));
        cycle(0, 0, 1, 0, 0, 32'h0);
        idle(3);
        cycle(0, 1, 0, DEPTH + 1, 0, 32'h0);
        cycle(0, 1, 0, 2, 0, 32'h0);
        cycle(0, 0, 0, 0, 1, 32'hD0);
        cycle(0, 0, 0, 0, 1, 32'hD1);
        idle(3);

        // A start during LOAD is ignored. A start in DONE reloads from address 0.
        cycle(0, 1, 0, 3, 0, 32'h0);
        cycle(0, 0, 0, 0, 1, 32'hE0);
        cycle(0, 1, 0, 6, 1, 32'hE1);
        cycle(0, 0, 0, 0, 1, 32'hE2);
        cycle(0, 0, 0, 0, 1, 32'hE3);
        idle(2);
        cycle(0, 1, 0, 2, 0, 32'h0);
        cycle(0, 0, 0, 0, 1, 32'hF0);
        cycle(0, 0, 0, 0, 1, 32'hF1);
        idle(2);

        // An abort while the final strobe is on the bus still completes that write and skips DONE.
        cycle(0, 1, 0, 1, 0, 32'h0);
        cycle(0, 0, 0, 0, 1, 32'h11);
        cycle(0, 0, 1, 0, 0, 32'h0);
        idle(2);

        // A reset in mid-load kills the pending strobe.
        cycle(0, 1, 0, 6, 0, 32'h0);
        cycle(0, 0, 0, 0, 1, 32'h21);
        cycle(0, 0, 0, 0, 1, 32'h22);
        cycle(1, 0, 0, 0, 1, 32'h23);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 19) == 0);
            ab = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) nw = $urandom_range(DEPTH + 1, (1 << CW) - 1);
            else                           nw = $urandom_range(1, 12);
            v  = ab ? 1'b0 : ($urandom_range(0, 3) != 0);
            cycle(0, st, ab, nw, v, $urandom);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
